pass_entry_loader: RTL and testbench

- Upstream write stage for the 16 x 256-bit password store.
- Accepts a byte stream from the host link through a valid/ready handshake and packs up to 32 bytes into one 256-bit entry.
- Issues a single-cycle write (data, address, write enable) into the next free store slot, and tracks slot occupancy, full and overflow status.

---
 rtl/pass_entry_loader_if.sv | 30 +++
 rtl/pass_entry_loader.sv | 164 ++++++++++++++++
 tb/tb_pass_entry_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pass_entry_loader_if.sv
// Host-link byte stream, store write port and status for pass_entry_loader.
// master: byte source / clear requester (drives in_* and clr_req).
// slave : the loader (drives in_ready, ram_*, entry_count, full, overflow, done).
interface pass_entry_loader_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              clr_req;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [ADDR_W:0]   entry_count;
  logic              full;
  logic              overflow;
  logic              done;

  modport master (
    output in_valid, in_data, in_last, clr_req,
    input  in_ready, ram_data, ram_addr, ram_we, entry_count, full, overflow, done
  );

  modport slave (
    input  in_valid, in_data, in_last, clr_req,
    output in_ready, ram_data, ram_addr, ram_we, entry_count, full, overflow, done
  );
endinterface

// File: rtl/pass_entry_loader.sv
// Packs a byte stream into DATA_W-bit password entries and writes each into the next free store slot.
// Latency: last byte accepted at edge N -> ram_we/done in cycle N+1 -> in_ready back in cycle N+2 (unless full).
// Backpressure: in_ready low while writing, clearing or full; held bytes stay with the source.
//
// Ports: clk, rst_n (async active-low); bus (slave modport): in_valid/in_data/in_last/in_ready byte
// stream, clr_req, ram_data/ram_addr/ram_we store write, entry_count/full/overflow status, done pulse.
// Optional feature macro PASS_LOADER_SCRUB_EN: clr_req zero-fills every slot before emptying the store.
module pass_entry_loader #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic               clk,
  input logic               rst_n,
  pass_entry_loader_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_DRAIN,
    S_WRITE
`ifdef PASS_LOADER_SCRUB_EN
    , S_CLEAR
`endif
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W:0]   r_count;     // doubles as the write pointer; never wraps
  logic              r_full;
  logic              r_ovf;
  logic              r_in_ready;
  logic              r_we;
  logic              r_done;
  logic [DATA_W-1:0] r_ram_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_clr_pend;  // clr_req seen during WRITE, acted on next cycle
`ifdef PASS_LOADER_SCRUB_EN
  logic [ADDR_W:0]   r_scrub;     // next slot to zero during the sweep
`endif

  logic              w_xfer;
  logic              w_clr;
  logic              w_will_full;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_wdata;

  assign w_xfer      = bus.in_valid && r_in_ready;
  assign w_clr       = bus.clr_req || r_clr_pend;
  assign w_will_full = (r_count + 1'b1) == DEPTH_CNT;
  assign w_merged    = r_buf | (DATA_W'(bus.in_data) << {r_idx, 3'b000});
  // In DRAIN the buffer already holds the first BYTES bytes; the extra ones are dropped.
  assign w_wdata     = (r_state == S_DRAIN) ? r_buf : w_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_COLLECT;
      r_idx      <= '0;
      r_buf      <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_ram_data <= '0;
      r_ram_addr <= '0;
      r_clr_pend <= 1'b0;
`ifdef PASS_LOADER_SCRUB_EN
      r_scrub    <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_WRITE: begin
          // The write always completes; a clear arriving now waits one cycle.
          r_count    <= r_count + 1'b1;
          r_full     <= w_will_full;
          r_clr_pend <= bus.clr_req;
          r_in_ready <= !w_will_full && !bus.clr_req;
          r_state    <= S_COLLECT;
        end
`ifdef PASS_LOADER_SCRUB_EN
        S_CLEAR: begin
          if (r_scrub == DEPTH_CNT) begin
            r_count    <= '0;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_COLLECT;
          end else begin
            r_we       <= 1'b1;
            r_ram_addr <= r_scrub[ADDR_W-1:0];
            r_ram_data <= '0;
            r_scrub    <= r_scrub + 1'b1;
          end
        end
`endif
        default: begin  // S_COLLECT, S_DRAIN
          if (w_clr) begin
            // Clear wins over a byte offered in the same cycle; that byte is not taken.
            r_clr_pend <= 1'b0;
            r_idx      <= '0;
            r_buf      <= '0;
`ifdef PASS_LOADER_SCRUB_EN
            r_state    <= S_CLEAR;
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_scrub    <= (ADDR_W + 1)'(1);
`else
            r_state    <= S_COLLECT;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
`endif
          end else if (w_xfer) begin
            if (bus.in_last) begin
              r_we       <= 1'b1;
              r_done     <= 1'b1;
              r_ram_addr <= r_count[ADDR_W-1:0];
              r_ram_data <= w_wdata;
              r_buf      <= '0;
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_WRITE;
            end else if (r_state == S_COLLECT) begin
              r_buf      <= w_merged;
              r_in_ready <= 1'b1;
              if (r_idx == LAST_IDX) begin
                r_ovf   <= 1'b1;
                r_idx   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end else begin
            r_in_ready <= (r_state == S_DRAIN) || !r_full;
          end
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.ram_we      = r_we;
  assign bus.done        = r_done;
  assign bus.ram_data    = r_ram_data;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.entry_count = r_count;
  assign bus.full        = r_full;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_pass_entry_loader.sv
module tb_pass_entry_loader;

  typedef struct packed {
    int unsigned  cyc;
    logic [3:0]   addr;
    logic [255:0] data;
    logic         done;
  } wr_t;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int n_checks;
  int n_fail;
  wr_t exp_q[$];
  wr_t obs_q[$];

  pass_entry_loader_if #(.DATA_W(256), .ADDR_W(4)) bus ();

  pass_entry_loader #(.DATA_W(256), .ADDR_W(4), .DEPTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and record any store write seen there.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (bus.ram_we === 1'b1) begin
      w.cyc  = cyc;
      w.addr = bus.ram_addr;
      w.data = bus.ram_data;
      w.done = bus.done;
      obs_q.push_back(w);
    end
  endtask

  // Offer one byte until it transfers; xfer_ok=0 if the budget runs out.
  task automatic send_byte(input logic [7:0] d, input logic last, output bit xfer_ok);
    xfer_ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !xfer_ok; i++) begin
      if (bus.in_ready === 1'b1) xfer_ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic push_exp(input int unsigned c, input logic [3:0] a, input logic [255:0] d, input logic dn);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d; w.done = dn;
    exp_q.push_back(w);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00; bus.clr_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = 8'h00; bus.clr_req = 1'b0;
    tick(); tick();
    n_checks++;
    if ({bus.in_ready, bus.ram_we, bus.done, bus.overflow, bus.full} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready/we/done/ovf/full=%b want 00000",
               {bus.in_ready, bus.ram_we, bus.done, bus.overflow, bus.full});
    end
    n_checks++;
    if ({bus.ram_addr, bus.entry_count} !== 9'd0 || bus.ram_data !== 256'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d count=%0d data=%h want all 0", bus.ram_addr, bus.entry_count, bus.ram_data);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_write();
    bit ok;
    wr_t e, o;
    logic [255:0] d;
    send_byte(8'h41, 1'b0, ok);
    send_byte(8'h42, 1'b0, ok);
    send_byte(8'h43, 1'b1, ok);
    d = 256'h434241;
    push_exp(cyc, 4'd0, d, 1'b1);
    n_checks++;
    if (!ok || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_during_write: xfer_ok=%0d in_ready=%b want 1,0", ok, bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.entry_count !== 5'd1) begin
      n_fail++; $display("FAIL basic_after_write: in_ready=%b count=%0d want 1,1", bus.in_ready, bus.entry_count);
    end
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL basic_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL basic_write: got cyc=%0d addr=%0d done=%b data=%h want cyc=%0d addr=%0d done=%b data=%h",
                             o.cyc, o.addr, o.done, o.data, e.cyc, e.addr, e.done, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL basic_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_fill();
    bit ok;
    bit ready_seen;
    wr_t e, o;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1, ok);
      push_exp(cyc, 4'(i), 256'(i), 1'b1);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.full !== 1'b1 || bus.entry_count !== 5'd16) begin
      n_fail++; $display("FAIL fill_full: full=%b count=%0d want 1,16", bus.full, bus.entry_count);
    end
    ready_seen = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hEE; bus.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_checks++;
    if (ready_seen) begin
      n_fail++; $display("FAIL fill_stall: in_ready rose while full, want 0");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL fill_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL fill_write: got cyc=%0d addr=%0d done=%b data=%h want cyc=%0d addr=%0d done=%b data=%h",
                             o.cyc, o.addr, o.done, o.data, e.cyc, e.addr, e.done, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL fill_extra: %0d writes while full, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_overflow();
    bit ok;
    wr_t e, o;
    logic [255:0] d;
    apply_reset();
    d = '0;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(k + 1);
    for (int k = 1; k <= 40; k++) send_byte(8'(k), (k == 40), ok);
    push_exp(cyc, 4'd0, d, 1'b1);
    repeat (2) tick();
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_set: overflow=%b want 1", bus.overflow);
    end
    send_byte(8'h55, 1'b1, ok);
    push_exp(cyc, 4'd1, 256'h55, 1'b1);
    repeat (3) tick();
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.entry_count !== 5'd2) begin
      n_fail++; $display("FAIL overflow_sticky: overflow=%b count=%0d want 1,2", bus.overflow, bus.entry_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL overflow_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL overflow_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL overflow_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  // Store holds 2 entries with overflow set from the previous scenario.
  task automatic test_clr_priority();
    bit ok;
    wr_t e, o;
    send_byte(8'h11, 1'b0, ok);
    send_byte(8'h12, 1'b0, ok);
    bus.in_valid = 1'b1; bus.in_data = 8'h13; bus.in_last = 1'b1; bus.clr_req = 1'b1;
`ifdef PASS_LOADER_SCRUB_EN
    for (int i = 0; i < 16; i++) push_exp(cyc + 1 + i, 4'(i), 256'd0, 1'b0);
`endif
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.clr_req = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (bus.entry_count !== 5'd0 || bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL clr_status: count=%0d ovf=%b full=%b want 0,0,0", bus.entry_count, bus.overflow, bus.full);
    end
    send_byte(8'h21, 1'b1, ok);
    push_exp(cyc, 4'd0, 256'h21, 1'b1);
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL clr_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL clr_write: got cyc=%0d addr=%0d done=%b data=%h want cyc=%0d addr=%0d done=%b data=%h",
                             o.cyc, o.addr, o.done, o.data, e.cyc, e.addr, e.done, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL clr_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_clr_in_write();
    bit ok;
    wr_t e, o;
    apply_reset();
    send_byte(8'h5A, 1'b1, ok);
    push_exp(cyc, 4'd0, 256'h5A, 1'b1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    n_checks++;
    if (bus.entry_count !== 5'd1) begin
      n_fail++; $display("FAIL clr_in_write_completes: count=%0d want 1", bus.entry_count);
    end
`ifdef PASS_LOADER_SCRUB_EN
    for (int i = 0; i < 16; i++) push_exp(cyc + 1 + i, 4'(i), 256'd0, 1'b0);
    repeat (18) tick();
`else
    tick();
`endif
    n_checks++;
    if (bus.entry_count !== 5'd0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_in_write_cleared: count=%0d in_ready=%b want 0,1", bus.entry_count, bus.in_ready);
    end
    repeat (2) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL clr_in_write_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL clr_in_write_write: got cyc=%0d addr=%0d done=%b data=%h want cyc=%0d addr=%0d done=%b data=%h",
                             o.cyc, o.addr, o.done, o.data, e.cyc, e.addr, e.done, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL clr_in_write_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    wr_t e, o;
    apply_reset();
    send_byte(8'h66, 1'b1, ok);
    repeat (2) tick();
    send_byte(8'h31, 1'b0, ok);
    send_byte(8'h32, 1'b0, ok);
    obs_q.delete();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.ram_we, bus.done, bus.overflow, bus.full, bus.entry_count, bus.ram_addr} !== 14'd0
        || bus.ram_data !== 256'd0) begin
      n_fail++; $display("FAIL async_reset_outputs: ready=%b count=%0d addr=%0d data=%h want all 0",
                         bus.in_ready, bus.entry_count, bus.ram_addr, bus.ram_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h77, 1'b1, ok);
    push_exp(cyc, 4'd0, 256'h77, 1'b1);
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL async_reset_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL async_reset_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL async_reset_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask

`ifdef PASS_LOADER_SCRUB_EN
  task automatic test_scrub();
    bit ok;
    wr_t e, o;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'hA0 + i), 1'b1, ok);
      push_exp(cyc, 4'(i), 256'(8'hA0 + i), 1'b1);
    end
    repeat (2) tick();
    bus.clr_req = 1'b1;
    for (int i = 0; i < 16; i++) push_exp(cyc + 1 + i, 4'(i), 256'd0, 1'b0);
    tick();
    bus.clr_req = 1'b0;
    repeat (16) tick();
    n_checks++;
    if (bus.entry_count !== 5'd0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL scrub_end: count=%0d in_ready=%b want 0,1", bus.entry_count, bus.in_ready);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL scrub_write: no write seen, want addr=%0d cyc=%0d", e.addr, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL scrub_write: got cyc=%0d addr=%0d done=%b data=%h want cyc=%0d addr=%0d done=%b data=%h",
                             o.cyc, o.addr, o.done, o.data, e.cyc, e.addr, e.done, e.data);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL scrub_extra: %0d extra writes, want 0", obs_q.size()); obs_q.delete();
    end
  endtask
`endif

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.clr_req = 1'b0;
    test_reset();
    test_basic_write();
    test_fill();
    test_overflow();
    test_clr_priority();
    test_clr_in_write();
    test_async_reset();
`ifdef PASS_LOADER_SCRUB_EN
    test_scrub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
